// File: rtl/morse_pkg.sv
// Shared constants, widths and config FSM encoding for the Morse timeout controller.
package morse_pkg;

   localparam int UNIT_W = 10;
   localparam int CNT_W  = 14;

   localparam logic [CNT_W-1:0] DASH_MULT  = 14'd2;
   localparam logic [CNT_W-1:0] INTER_MULT = 14'd3;
   localparam logic [CNT_W-1:0] WORD_MULT  = 14'd7;
   localparam logic [CNT_W-1:0] BTN_MULT   = 14'd10;

   typedef enum logic [0:0] {
      CFG_IDLE  = 1'b0,
      CFG_APPLY = 1'b1
   } cfg_state_e;

   // 1023 * 10 = 10230 fits in CNT_W bits, so the product never overflows.
   function automatic logic [CNT_W-1:0] unit_scale(input logic [UNIT_W-1:0] unit,
                                                   input logic [CNT_W-1:0]  mult);
      return {{(CNT_W-UNIT_W){1'b0}}, unit} * mult;
   endfunction

endpackage

// File: rtl/morse_timeout_ctr.sv
// One millisecond-tick timeout counter with a sticky flag that holds until cleared.
module morse_timeout_ctr
   import morse_pkg::*;
(
   input  logic             clk_100MHz,
   input  logic             reset,
   input  logic             clr,
   input  logic             tick,
   input  logic [CNT_W-1:0] threshold,
   output logic             to
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   assign cnt_next = cnt + 14'd1;

   // clr wins over a coincident tick; once the flag is set the count freezes.
   always_ff @(posedge clk_100MHz) begin
      if (reset || clr) begin
         cnt <= '0;
         to  <= 1'b0;
      end else if (tick && !to) begin
         cnt <= cnt_next;
         if (cnt_next == threshold) begin
            to <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/morse_timer_ctrl.sv
// Four independent Morse timeouts driven by a shared 1 ms prescaler and a runtime-configurable unit length.
module morse_timer_ctrl
   import morse_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 100000,
   parameter int unsigned UNIT_MS_RST = 60
) (
   input  logic              clk_100MHz,
   input  logic              reset,
   input  logic              btn_to_res,
   input  logic              dash_to_res,
   input  logic              inter_to_res,
   input  logic              word_to_res,
   output logic              btn_to,
   output logic              dash_to,
   output logic              inter_to,
   output logic              word_to,
   input  logic [UNIT_W-1:0] cfg_unit_ms,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic [0:0]        cfg_state
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   localparam logic [0:0] ST_IDLE  = 1'(CFG_IDLE);
   localparam logic [0:0] ST_APPLY = 1'(CFG_APPLY);

   logic [PRE_W-1:0]  presc;
   logic              tick;
   logic [UNIT_W-1:0] unit_q;
   logic [0:0]        state_q;
   logic              accept;
   logic [CNT_W-1:0]  dash_thr;
   logic [CNT_W-1:0]  inter_thr;
   logic [CNT_W-1:0]  word_thr;
   logic [CNT_W-1:0]  btn_thr;

   // Handshake: a config word is taken on any edge where cfg_valid && cfg_ready.
   assign cfg_ready = (state_q == ST_IDLE);
   assign cfg_state = state_q;
   assign accept    = cfg_ready && cfg_valid;
   assign tick      = (presc == PRE_MAX);

   // The prescaler only restarts on reset or a new unit, never on a *_res clear.
   always_ff @(posedge clk_100MHz) begin
      if (reset || accept) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q <= ST_IDLE;
         unit_q  <= UNIT_W'(UNIT_MS_RST);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cfg_valid) begin
                  unit_q  <= (cfg_unit_ms == '0) ? UNIT_W'(1) : cfg_unit_ms;
                  state_q <= ST_APPLY;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign dash_thr  = unit_scale(unit_q, DASH_MULT);
   assign inter_thr = unit_scale(unit_q, INTER_MULT);
   assign word_thr  = unit_scale(unit_q, WORD_MULT);
   assign btn_thr   = unit_scale(unit_q, BTN_MULT);

   morse_timeout_ctr u_dash (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .clr        (dash_to_res || accept),
      .tick       (tick),
      .threshold  (dash_thr),
      .to         (dash_to)
   );

   morse_timeout_ctr u_inter (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .clr        (inter_to_res || accept),
      .tick       (tick),
      .threshold  (inter_thr),
      .to         (inter_to)
   );

   morse_timeout_ctr u_word (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .clr        (word_to_res || accept),
      .tick       (tick),
      .threshold  (word_thr),
      .to         (word_to)
   );

   morse_timeout_ctr u_btn (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .clr        (btn_to_res || accept),
      .tick       (tick),
      .threshold  (btn_thr),
      .to         (btn_to)
   );

endmodule
